// File: rtl/sram_sim_pkg.sv
// Shared types and constants for the behavioural 1W1R harness SRAM.
package sram_sim_pkg;

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_t;

    localparam int unsigned RDW_READ_OLD    = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;
    localparam int unsigned RD_LAT_MAX      = 4;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: RD_LAT stages of {valid, data}; the last stage holds
// its data between results so the read port never shows stale garbage.
module sram_rd_pipe
    import sram_sim_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("sram_rd_pipe: RD_LAT must be within 1..%0d", RD_LAT_MAX);
    end

    logic              r_vld [RD_LAT];
    logic [DATA_W-1:0] r_dat [RD_LAT];

    // Data only advances alongside a valid bit, so every stage (and the
    // output stage in particular) keeps the last real result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                r_vld[k] <= 1'b0;
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_dat[0] <= i_data;
            end
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign o_valid = r_vld[RD_LAT-1];
    assign o_data  = r_dat[RD_LAT-1];

endmodule

// File: rtl/behav_sram_1w1r.sv
// Behavioural 1-write/1-read SRAM with lane-masked writes, programmable read
// latency, selectable read-during-write policy and a zero-fill clear engine.
module behav_sram_1w1r
    import sram_sim_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned MASK_GRAN = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned RDW_MODE  = RDW_READ_OLD
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           W0_addr,
    input  logic                        W0_en,
    input  logic [DATA_W-1:0]           W0_data,
    input  logic [DATA_W/MASK_GRAN-1:0] W0_mask,
    input  logic [ADDR_W-1:0]           R0_addr,
    input  logic                        R0_en,
    output logic [DATA_W-1:0]           R0_data,
    output logic                        R0_valid,
    input  logic                        clr_req,
    output logic                        clr_busy
);

    localparam int unsigned MASK_W = DATA_W / MASK_GRAN;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    if (DATA_W % MASK_GRAN != 0) begin : g_bad_gran
        $error("behav_sram_1w1r: DATA_W must be a multiple of MASK_GRAN");
    end
    if (RDW_MODE > RDW_WRITE_FIRST) begin : g_bad_rdw
        $error("behav_sram_1w1r: RDW_MODE must be 0 or 1");
    end

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;
    logic              w_clr_we;
    logic              w_busy;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_collide;
    logic [DATA_W-1:0] w_lane_bits;
    logic [DATA_W-1:0] w_rd_old;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] r_mem [DEPTH];

    assign w_busy   = (r_state == CLR_RUN);
    assign clr_busy = w_busy;
    assign w_wr_acc = W0_en && !w_busy && !reset;
    assign w_rd_acc = R0_en && !w_busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= CLR_IDLE;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_clr_we      = 1'b0;
        unique case (r_state)
            CLR_IDLE: begin
                if (clr_req) begin
                    w_state_nxt   = CLR_RUN;
                    w_clr_ptr_nxt = '0;
                end
            end
            CLR_RUN: begin
                w_clr_we      = 1'b1;
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (&r_clr_ptr) begin
                    w_state_nxt   = CLR_IDLE;
                    w_clr_ptr_nxt = '0;
                end
            end
            default: w_state_nxt = CLR_IDLE;
        endcase
    end

    always_comb begin
        w_lane_bits = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            w_lane_bits[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{W0_mask[i]}};
        end
    end

    // Array contents deliberately survive reset; only the clear engine zeroes them.
    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[W0_addr] <= (r_mem[W0_addr] & ~w_lane_bits) | (W0_data & w_lane_bits);
        end
    end

    assign w_rd_old  = r_mem[R0_addr];
    assign w_collide = w_wr_acc && (W0_addr == R0_addr);

    always_comb begin
        w_rd_word = w_rd_old;
        if (RDW_MODE == RDW_WRITE_FIRST && w_collide) begin
            w_rd_word = (w_rd_old & ~w_lane_bits) | (W0_data & w_lane_bits);
        end
    end

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clock   (clock),
        .reset   (reset),
        .i_valid (w_rd_acc),
        .i_data  (w_rd_word),
        .o_valid (R0_valid),
        .o_data  (R0_data)
    );

endmodule

// File: tb/tb_behav_sram_1w1r.sv
// Random and directed checks of three SRAM variants (latency/RDW policy)
// driven in lockstep and compared against a word-array reference model.
module tb_behav_sram_1w1r;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned NI    = 3;
    localparam int unsigned LAT  [NI] = '{1, 3, 4};
    localparam int unsigned MODE [NI] = '{0, 0, 1};

    logic        clock;
    logic        reset;
    logic [5:0]  W0_addr;
    logic        W0_en;
    logic [63:0] W0_data;
    logic [7:0]  W0_mask;
    logic [5:0]  R0_addr;
    logic        R0_en;
    logic        clr_req;
    logic [63:0] rd_data  [NI];
    logic        rd_valid [NI];
    logic        busy     [NI];

    behav_sram_1w1r #(.DATA_W(64), .ADDR_W(6), .MASK_GRAN(8), .RD_LAT(1), .RDW_MODE(0)) u_dut0 (
        .clock(clock), .reset(reset), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
        .W0_mask(W0_mask), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rd_data[0]),
        .R0_valid(rd_valid[0]), .clr_req(clr_req), .clr_busy(busy[0]));

    behav_sram_1w1r #(.DATA_W(64), .ADDR_W(6), .MASK_GRAN(8), .RD_LAT(3), .RDW_MODE(0)) u_dut1 (
        .clock(clock), .reset(reset), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
        .W0_mask(W0_mask), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rd_data[1]),
        .R0_valid(rd_valid[1]), .clr_req(clr_req), .clr_busy(busy[1]));

    behav_sram_1w1r #(.DATA_W(64), .ADDR_W(6), .MASK_GRAN(8), .RD_LAT(4), .RDW_MODE(1)) u_dut2 (
        .clock(clock), .reset(reset), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
        .W0_mask(W0_mask), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rd_data[2]),
        .R0_valid(rd_valid[2]), .clr_req(clr_req), .clr_busy(busy[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: plain word array, a clear countdown and a per-variant
    // schedule of which edge each read result is due on.
    logic [63:0] m_mem [DEPTH];
    int unsigned m_clr_left;
    int unsigned edge_n;
    bit          sched_v [NI][8];
    logic [63:0] sched_d [NI][8];
    logic [63:0] m_hold  [NI];
    int          n_vec;
    int          n_err;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lanes(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic model_reset();
        m_clr_left = 0;
        for (int i = 0; i < NI; i++) begin
            m_hold[i] = '0;
            for (int s = 0; s < 8; s++) begin
                sched_v[i][s] = 1'b0;
                sched_d[i][s] = '0;
            end
        end
    endtask

    task automatic model_edge();
        logic [63:0] bm, old_w, new_w;
        int slot;
        if (reset) return;
        if (m_clr_left != 0) begin
            m_mem[DEPTH - m_clr_left] = '0;
            m_clr_left--;
            return;
        end
        bm = lanes(W0_mask);
        if (R0_en) begin
            old_w = m_mem[R0_addr];
            new_w = (W0_en && W0_addr == R0_addr) ? ((old_w & ~bm) | (W0_data & bm)) : old_w;
            for (int i = 0; i < NI; i++) begin
                slot = int'((edge_n + LAT[i]) % 8);
                sched_v[i][slot] = 1'b1;
                sched_d[i][slot] = (MODE[i] == 1) ? new_w : old_w;
            end
        end
        if (W0_en) m_mem[W0_addr] = (m_mem[W0_addr] & ~bm) | (W0_data & bm);
        if (clr_req) m_clr_left = DEPTH;
    endtask

    task automatic check_outputs();
        int slot;
        bit ev;
        slot = int'(edge_n % 8);
        for (int i = 0; i < NI; i++) begin
            ev = sched_v[i][slot];
            if (ev) m_hold[i] = sched_d[i][slot];
            sched_v[i][slot] = 1'b0;
            chk_eq($sformatf("valid[%0d]@%0d", i, edge_n), {63'b0, rd_valid[i]}, {63'b0, ev});
            chk_eq($sformatf("data[%0d]@%0d", i, edge_n), rd_data[i], m_hold[i]);
            chk_eq($sformatf("busy[%0d]@%0d", i, edge_n), {63'b0, busy[i]}, {63'b0, m_clr_left != 0});
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        edge_n++;
        #1;
        check_outputs();
    endtask

    task automatic set_idle();
        W0_en = 1'b0; W0_addr = '0; W0_data = '0; W0_mask = '0;
        R0_en = 1'b0; R0_addr = '0; clr_req = 1'b0;
    endtask

    task automatic cyc(input logic we, input logic [5:0] wa, input logic [63:0] wd, input logic [7:0] wm,
                       input logic re, input logic [5:0] ra, input logic cr);
        W0_en = we; W0_addr = wa; W0_data = wd; W0_mask = wm;
        R0_en = re; R0_addr = ra; clr_req = cr;
        step();
        set_idle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic mid_cycle_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            chk_eq($sformatf("rst_valid[%0d]", i), {63'b0, rd_valid[i]}, 64'd0);
            chk_eq($sformatf("rst_data[%0d]", i), rd_data[i], 64'd0);
            chk_eq($sformatf("rst_busy[%0d]", i), {63'b0, busy[i]}, 64'd0);
        end
        step();
        #2 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        n_vec = 0; n_err = 0; edge_n = 0;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        set_idle();
        model_reset();
        reset = 1'b1;
        idle(3);
        #2 reset = 1'b0;

        // Full clear; an access and a second clr_req during busy must be dropped.
        cyc(0, 0, 0, 0, 0, 0, 1);
        busy_cnt = 0;
        for (int k = 0; k < 200 && busy[0]; k++) begin
            if (k == 3) cyc(1, 6'd3, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1, 6'd3, 1);
            else        step();
            busy_cnt++;
        end
        chk_eq("clear_busy_cycles", 64'(busy_cnt), 64'(DEPTH));
        for (int a = 0; a < DEPTH; a++) cyc(0, 0, 0, 0, 1, 6'(a), 0);
        idle(5);

        // Lane-masked write merge at 0x10.
        cyc(1, 6'h10, 64'h1122334455667788, 8'hFF, 0, 0, 0);
        cyc(1, 6'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 6'h10, 0);
        idle(5);
        for (int i = 0; i < NI; i++)
            chk_eq($sformatf("mask_merge[%0d]", i), rd_data[i], 64'h11223344AAAAAAAA);

        // Same-address read during write at 0x20 (old contents zero).
        cyc(1, 6'h20, 64'hFFFFFFFFFFFFFFFF, 8'h01, 1, 6'h20, 0);
        idle(5);
        chk_eq("rdw_old[0]", rd_data[0], 64'h0);
        chk_eq("rdw_old[1]", rd_data[1], 64'h0);
        chk_eq("rdw_first[2]", rd_data[2], 64'h00000000000000FF);
        cyc(0, 0, 0, 0, 1, 6'h20, 0);
        idle(5);

        // Back-to-back reads of fresh data, then held output.
        for (int a = 0; a < 3; a++) cyc(1, 6'(a), {$urandom, $urandom}, 8'hFF, 0, 0, 0);
        for (int a = 0; a < 3; a++) cyc(0, 0, 0, 0, 1, 6'(a), 0);
        idle(6);

        // Random traffic concentrated on a few addresses to provoke collisions.
        for (int k = 0; k < 400; k++)
            cyc(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom),
                1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 149) == 0));
        for (int k = 0; k < 100 && m_clr_left != 0; k++) step();
        idle(5);

        // Reset partway through a clear: entries 0..4 zeroed, 5..15 intact.
        for (int a = 0; a < 16; a++) cyc(1, 6'(a), {$urandom, $urandom}, 8'hFF, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(5);
        mid_cycle_reset();
        for (int a = 0; a < 16; a++) cyc(0, 0, 0, 0, 1, 6'(a), 0);
        idle(5);

        // Reset with reads still in flight: flushed, array unchanged.
        cyc(0, 0, 0, 0, 1, 6'd5, 0);
        cyc(0, 0, 0, 0, 1, 6'd6, 0);
        cyc(0, 0, 0, 0, 1, 6'd7, 0);
        step();
        mid_cycle_reset();
        idle(6);
        for (int a = 5; a < 8; a++) cyc(0, 0, 0, 0, 1, 6'(a), 0);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
